// File: rtl/fpga_inference_scheduler_if.sv
// Request/result bus between the feature channels, the scheduler and the order path.
interface fpga_inference_scheduler_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
);
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [NUM_CH*16-1:0] req_imbalance;
    logic [NUM_CH*8-1:0]  req_intensity;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH_W-1:0]      out_channel;
    logic                 out_prediction;
    logic                 out_suppressed;

    // Scheduler side
    modport slave (
        input  req_valid, req_imbalance, req_intensity, out_ready,
        output req_ready, out_valid, out_channel, out_prediction, out_suppressed
    );

    // Channel/order-path side
    modport master (
        output req_valid, req_imbalance, req_intensity, out_ready,
        input  req_ready, out_valid, out_channel, out_prediction, out_suppressed
    );
endinterface

// File: rtl/fpga_inference_scheduler.sv
// Round-robin scheduler sharing one combinational inference engine among
// NUM_CH feature channels, with a one-entry valid/ready result slot.
// Optional feature macro: QARB_SIGNAL_COOLDOWN_EN (per-channel UP cooldown).
module fpga_inference_scheduler #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned COOLDOWN   = 16,
    parameter int unsigned COOLDOWN_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sched_en,
    fpga_inference_scheduler_if.slave     bus,
    output logic [15:0]                   eng_book_imbalance,
    output logic [7:0]                    eng_trade_intensity,
    input  logic                          eng_prediction,
    output logic [15:0]                   up_count
);

    localparam int unsigned IDX_W = CH_W + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t       state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic              found;
    logic [IDX_W-1:0]  idx;
    logic              slot_free;
    logic              accept;
    logic [NUM_CH-1:0] cd_active;
    logic              fin_pred;
    logic              blocked;
    logic [CH_W-1:0]   out_channel_q;
    logic              out_prediction_q;
    logic              out_suppressed_q;

    // First requesting channel at or after rr_ptr, wrapping at NUM_CH
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IDX_W'(rr_ptr) + IDX_W'(k);
            if (idx >= IDX_W'(NUM_CH)) begin
                idx = idx - IDX_W'(NUM_CH);
            end
            if (!found && bus.req_valid[idx[CH_W-1:0]]) begin
                found = 1'b1;
                grant = idx[CH_W-1:0];
            end
        end
    end

    assign slot_free = (state == S_EMPTY) || bus.out_ready;
    assign accept    = sched_en && found && slot_free;

    // One-hot ready for the granted channel on its accept cycle
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant] = 1'b1;
        end
    end

    // Present the granted channel's features to the engine, zero otherwise
    always_comb begin
        eng_book_imbalance  = '0;
        eng_trade_intensity = '0;
        if (accept) begin
            eng_book_imbalance  = bus.req_imbalance[{grant, 4'b0000} +: 16];
            eng_trade_intensity = bus.req_intensity[{grant, 3'b000} +: 8];
        end
    end

    assign fin_pred = eng_prediction && !cd_active[grant];
    assign blocked  = eng_prediction && cd_active[grant];

`ifdef QARB_SIGNAL_COOLDOWN_EN
    logic [COOLDOWN_W-1:0] cd_cnt [NUM_CH];

    // Per-channel cooldown: reload on emitted UP, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cd_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (accept && (grant == CH_W'(i)) && fin_pred) begin
                    cd_cnt[i] <= COOLDOWN_W'(COOLDOWN);
                end else if (cd_cnt[i] != '0) begin
                    cd_cnt[i] <= cd_cnt[i] - COOLDOWN_W'(1);
                end
            end
        end
    end

    // Channel is inside its suppression window
    always_comb begin
        cd_active = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cd_active[i] = (cd_cnt[i] != '0);
        end
    end
`else
    logic unused_cfg;

    assign cd_active  = '0;
    assign unused_cfg = ^(8'(COOLDOWN) ^ 8'(COOLDOWN_W));
`endif

    // Output-slot FSM, round-robin pointer, result capture and UP counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_EMPTY;
            rr_ptr           <= '0;
            out_channel_q    <= '0;
            out_prediction_q <= 1'b0;
            out_suppressed_q <= 1'b0;
            up_count         <= '0;
        end else begin
            if (accept) begin
                rr_ptr           <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
                out_channel_q    <= grant;
                out_prediction_q <= fin_pred;
                out_suppressed_q <= blocked;
                if (fin_pred && (up_count != 16'hFFFF)) begin
                    up_count <= up_count + 16'd1;
                end
            end
            case (state)
                S_EMPTY: if (accept) state <= S_FULL;
                S_FULL:  if (!accept && bus.out_ready) state <= S_EMPTY;
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign bus.out_valid      = (state == S_FULL);
    assign bus.out_channel    = out_channel_q;
    assign bus.out_prediction = out_prediction_q;
    assign bus.out_suppressed = out_suppressed_q;

endmodule

// File: tb/tb_fpga_inference_scheduler.sv
// Directed bench for fpga_inference_scheduler with a result scoreboard and a
// behavioural engine (UP when imbalance > 614 signed and intensity > 25).
module tb_fpga_inference_scheduler;

    localparam int unsigned COOLDOWN = 16;

    typedef struct packed {
        logic [1:0] ch;
        logic       pred;
        logic       supp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        sched_en;
    logic [15:0] eng_book_imbalance;
    logic [7:0]  eng_trade_intensity;
    logic        eng_prediction;
    logic [15:0] up_count;

    logic [15:0] imb   [4];
    logic [7:0]  inten [4];

    int n_chk;
    int n_fail;

    logic [1:0]  m_rr;
    logic        m_valid;
    logic [15:0] m_up;
`ifdef QARB_SIGNAL_COOLDOWN_EN
    int          m_cd [4];
`endif
    exp_t        held;
    exp_t        q [$];
    logic [3:0]  last_ready;
    logic [1:0]  saved_ch;

    fpga_inference_scheduler_if #(.NUM_CH(4), .CH_W(2)) bus ();

    fpga_inference_scheduler dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sched_en            (sched_en),
        .bus                 (bus),
        .eng_book_imbalance  (eng_book_imbalance),
        .eng_trade_intensity (eng_trade_intensity),
        .eng_prediction      (eng_prediction),
        .up_count            (up_count)
    );

    function automatic logic eng_model(input logic [15:0] im, input logic [7:0] it);
        return ($signed(im) > 16'sd614) && (it > 8'd25);
    endfunction

    assign eng_prediction    = eng_model(eng_book_imbalance, eng_trade_intensity);
    assign bus.req_imbalance = {imb[3], imb[2], imb[1], imb[0]};
    assign bus.req_intensity = {inten[3], inten[2], inten[1], inten[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_rr    = 2'd0;
        m_valid = 1'b0;
        m_up    = 16'd0;
`ifdef QARB_SIGNAL_COOLDOWN_EN
        for (int i = 0; i < 4; i++) m_cd[i] = 0;
`endif
        q.delete();
        held = '0;
    endtask

    // One clock: drive, check combinational outputs, push expectation,
    // clock, pop and check the registered result.
    task automatic step(input logic en, input logic [3:0] v, input logic ordy);
        logic       acc;
        logic       found;
        logic [1:0] g;
        logic [1:0] c;
        logic [3:0] exp_rdy;
        logic       up;
        logic       blk;
        exp_t       e;
        sched_en      = en;
        bus.req_valid = v;
        bus.out_ready = ordy;
        #1;
        found = 1'b0;
        g     = 2'd0;
        for (int k = 0; k < 4; k++) begin
            c = m_rr + 2'(k);
            if (!found && v[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        acc        = en && found && (!m_valid || ordy);
        exp_rdy    = acc ? (4'b0001 << g) : 4'b0000;
        last_ready = bus.req_ready;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("eng_imbalance", 32'(eng_book_imbalance), 32'(acc ? imb[g] : 16'd0));
        chk("eng_intensity", 32'(eng_trade_intensity), 32'(acc ? inten[g] : 8'd0));
        up  = 1'b0;
        blk = 1'b0;
        if (acc) begin
            up = eng_model(imb[g], inten[g]);
`ifdef QARB_SIGNAL_COOLDOWN_EN
            if (m_cd[g] != 0) begin
                blk = up;
                up  = 1'b0;
            end
`endif
            e.ch   = g;
            e.pred = up;
            e.supp = blk;
            q.push_back(e);
        end
        @(posedge clk);
`ifdef QARB_SIGNAL_COOLDOWN_EN
        for (int i = 0; i < 4; i++) begin
            if (acc && up && (g == 2'(i))) m_cd[i] = COOLDOWN;
            else if (m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
        end
`endif
        if (acc) begin
            m_rr    = g + 2'd1;
            m_valid = 1'b1;
            if (up && (m_up != 16'hFFFF)) m_up = m_up + 16'd1;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        if (acc) held = q.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("up_count", 32'(up_count), 32'(m_up));
        if (m_valid) begin
            chk("out_channel", 32'(bus.out_channel), 32'(held.ch));
            chk("out_prediction", 32'(bus.out_prediction), 32'(held.pred));
            chk("out_suppressed", 32'(bus.out_suppressed), 32'(held.supp));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] rr_exp [5];
        n_chk  = 0;
        n_fail = 0;
        model_reset();
        last_ready    = '0;
        rst_n         = 1'b0;
        sched_en      = 1'b0;
        bus.req_valid = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            imb[i]   = '0;
            inten[i] = '0;
        end

        // Reset state
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_channel", 32'(bus.out_channel), 32'd0);
        chk("rst_out_prediction", 32'(bus.out_prediction), 32'd0);
        chk("rst_out_suppressed", 32'(bus.out_suppressed), 32'd0);
        chk("rst_up_count", 32'(up_count), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transaction on channel 2
        imb[2]   = 16'd700;
        inten[2] = 8'd30;
        step(1'b1, 4'b0100, 1'b1);
        chk("first_req_ready", 32'(last_ready), 32'(4'b0100));
        chk("first_out_valid", 32'(bus.out_valid), 32'd1);
        chk("first_out_channel", 32'(bus.out_channel), 32'd2);
        chk("first_out_prediction", 32'(bus.out_prediction), 32'd1);
        chk("first_up_count", 32'(up_count), 32'd1);

        // Round-robin over all four channels, starting from pointer 0
        step(1'b1, 4'b1000, 1'b1);
        imb[0] = 16'd700; inten[0] = 8'd30;
        imb[1] = 16'd100; inten[1] = 8'd10;
        imb[2] = 16'd615; inten[2] = 8'd26;
        imb[3] = 16'd614; inten[3] = 8'd30;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 1'b1);
            chk("rr_grant", 32'(last_ready), 32'(rr_exp[i]));
        end

        // Backpressure: held result stays put, no grants
        step(1'b1, 4'b1111, 1'b1);
        saved_ch = bus.out_channel;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 1'b0);
            chk("bp_req_ready", 32'(last_ready), 32'd0);
            chk("bp_out_channel", 32'(bus.out_channel), 32'(saved_ch));
        end
        step(1'b1, 4'b1111, 1'b1);
        chk("bp_release_grant", 32'(last_ready != 4'b0000), 32'd1);
        step(1'b1, 4'b0000, 1'b1);

        // Cooldown on channel 1
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0000, 1'b1);
        imb[1] = 16'd700; inten[1] = 8'd30;
        step(1'b1, 4'b0010, 1'b1);
        chk("cd_first_up", 32'(bus.out_prediction), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
`ifdef QARB_SIGNAL_COOLDOWN_EN
        chk("cd_suppressed_pred", 32'(bus.out_prediction), 32'd0);
        chk("cd_suppressed_flag", 32'(bus.out_suppressed), 32'd1);
`else
        chk("cd_off_pred", 32'(bus.out_prediction), 32'd1);
        chk("cd_off_flag", 32'(bus.out_suppressed), 32'd0);
`endif
        for (int i = 0; i < 11; i++) step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
        chk("cd_expired_up", 32'(bus.out_prediction), 32'd1);

        // Boundary features and negative imbalance
        imb[0] = 16'd614; inten[0] = 8'd30;
        imb[3] = 16'd615; inten[3] = 8'd25;
        imb[2] = 16'hFD44; inten[2] = 8'd30;
        saved_ch = 2'd0;
        step(1'b1, 4'b0001, 1'b1);
        chk("bnd_614_pred", 32'(bus.out_prediction), 32'd0);
        step(1'b1, 4'b1000, 1'b1);
        chk("bnd_615_pred", 32'(bus.out_prediction), 32'd0);
        step(1'b1, 4'b0100, 1'b1);
        chk("bnd_neg_pred", 32'(bus.out_prediction), 32'd0);

        // Enable off: held result drains, no new grants
        step(1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        chk("en_off_hold_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            chk("en_off_req_ready", 32'(last_ready), 32'd0);
        end

`ifndef QARB_SIGNAL_COOLDOWN_EN
        // Saturation: 65536 back-to-back UP accepts
        for (int i = 0; i < 4; i++) begin
            imb[i]   = 16'd700;
            inten[i] = 8'd30;
        end
        sched_en      = 1'b1;
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        m_up    = 16'hFFFF;
        m_valid = 1'b1;
        held    = '{ch: m_rr - 2'd1, pred: 1'b1, supp: 1'b0};
        chk("sat_up_count", 32'(up_count), 32'h0000FFFF);
        step(1'b1, 4'b1111, 1'b1);
        chk("sat_hold", 32'(up_count), 32'h0000FFFF);
`endif

        // Reset mid-operation drops the held result and clears the pointer
        step(1'b1, 4'b0100, 1'b0);
        bus.req_valid = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_up_count", 32'(up_count), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("mid_rst_out_channel", 32'(bus.out_channel), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 4'b1111, 1'b1);
        chk("post_rst_grant", 32'(last_ready), 32'(4'b0001));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
